// File: rtl/imem_banked_if.sv
// Fetch, response and loader signals shared by imem_banked and its users.
interface imem_banked_if #(
  parameter int INSN_LEN = 32,
  parameter int FETCH_W  = 4,
  parameter int DEPTH    = 512
);
  localparam int AW = $clog2(DEPTH) + $clog2(FETCH_W);

  logic                        req_valid;
  logic [AW-1:0]               req_addr;
  logic                        req_ready;
  logic                        stall;
  logic                        rsp_valid;
  logic [AW-1:0]               rsp_addr;
  logic [FETCH_W*INSN_LEN-1:0] rsp_data;
  logic                        ld_valid;
  logic [AW-1:0]               ld_addr;
  logic [INSN_LEN-1:0]         ld_data;
  logic                        ld_ready;
  logic [AW:0]                 ld_count;

  modport master (
    output req_valid, req_addr, stall, ld_valid, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_addr, rsp_data, ld_ready, ld_count
  );

  modport slave (
    input  req_valid, req_addr, stall, ld_valid, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_addr, rsp_data, ld_ready, ld_count
  );
endinterface

// File: rtl/imem_banked.sv
// Banked instruction memory: FETCH_W consecutive words from any word address,
// wrapping across rows and past the top of memory, with a priority loader port.
module imem_banked #(
  parameter int INSN_LEN = 32,
  parameter int FETCH_W  = 4,
  parameter int DEPTH    = 512,
  parameter bit WRITE_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  imem_banked_if.slave bus
);
  localparam int AW = $clog2(DEPTH) + $clog2(FETCH_W);
  localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
  localparam int DW = FETCH_W * INSN_LEN;

  typedef logic [AW:0] cnt_t;

  logic [INSN_LEN-1:0] mem_r [FETCH_W][DEPTH];

  logic                rsp_valid_r;
  logic [AW-1:0]       rsp_addr_r;
  logic [DW-1:0]       rsp_data_r;
  cnt_t                ld_count_r;

  logic                write_s;
  logic                fetch_s;
  logic [OW-1:0]       off_s;
  logic [RW-1:0]       row_s;
  logic [RW-1:0]       bank_row_s [FETCH_W];
  logic [DW-1:0]       read_data_s;

  function automatic logic [OW-1:0] bank_of(input logic [AW-1:0] a);
    return OW'(a % AW'(FETCH_W));
  endfunction

  function automatic logic [RW-1:0] row_of(input logic [AW-1:0] a);
    return RW'(a / AW'(FETCH_W));
  endfunction

  // Arbitration, per-bank row selection and lane rotation of the read words
  always_comb begin
    write_s     = WRITE_EN && bus.ld_valid;
    fetch_s     = bus.req_valid && !write_s && !(rsp_valid_r && bus.stall);
    off_s       = bank_of(bus.req_addr);
    row_s       = row_of(bus.req_addr);
    read_data_s = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      // banks below the start offset hold the words that spill into the next row
      if (OW'(i) < off_s) begin
        bank_row_s[i] = row_s + RW'(1);
      end else begin
        bank_row_s[i] = row_s;
      end
    end
    for (int k = 0; k < FETCH_W; k++) begin
      read_data_s[k*INSN_LEN +: INSN_LEN] =
        mem_r[off_s + OW'(k)][bank_row_s[off_s + OW'(k)]];
    end
  end

  // Loader writes into storage, which is deliberately left without reset
  always_ff @(posedge clk) begin
    if (write_s) begin
      mem_r[bank_of(bus.ld_addr)][row_of(bus.ld_addr)] <= bus.ld_data;
    end
  end

  // Response register: capture on accepted fetch, hold under stall, else drop valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_r <= 1'b0;
      rsp_addr_r  <= '0;
      rsp_data_r  <= '0;
    end else if (fetch_s) begin
      rsp_valid_r <= 1'b1;
      rsp_addr_r  <= bus.req_addr;
      rsp_data_r  <= read_data_s;
    end else if (rsp_valid_r && bus.stall) begin
      rsp_valid_r <= 1'b1;
    end else begin
      rsp_valid_r <= 1'b0;
    end
  end

  // Count of accepted loader writes, wrapping naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_count_r <= '0;
    end else if (write_s) begin
      ld_count_r <= ld_count_r + cnt_t'(1);
    end else begin
      ld_count_r <= ld_count_r;
    end
  end

  assign bus.req_ready = !write_s && !(rsp_valid_r && bus.stall);
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_addr  = rsp_addr_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.ld_ready  = WRITE_EN;
  assign bus.ld_count  = ld_count_r;
endmodule

// File: tb/tb_imem_banked.sv
// Directed, table-driven bench for imem_banked (loader enabled and disabled instances).
module tb_imem_banked;
  localparam int INSN_LEN = 32;
  localparam int FETCH_W  = 4;
  localparam int DEPTH    = 512;
  localparam int AW       = 11;
  localparam int DW       = 128;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  imem_banked_if #(.INSN_LEN(INSN_LEN), .FETCH_W(FETCH_W), .DEPTH(DEPTH)) b ();
  imem_banked_if #(.INSN_LEN(INSN_LEN), .FETCH_W(FETCH_W), .DEPTH(DEPTH)) b0 ();

  imem_banked #(.INSN_LEN(INSN_LEN), .FETCH_W(FETCH_W), .DEPTH(DEPTH), .WRITE_EN(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(b)
  );
  imem_banked #(.INSN_LEN(INSN_LEN), .FETCH_W(FETCH_W), .DEPTH(DEPTH), .WRITE_EN(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(b0)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } vec_t;
  vec_t vecs[8];
  logic [DW-1:0] before_s;

  function automatic logic [DW-1:0] lanes(input logic [31:0] l0, input logic [31:0] l1,
                                          input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    b.ld_valid = 1'b1;
    b.ld_addr  = a;
    b.ld_data  = d;
    tick();
    b.ld_valid = 1'b0;
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    b.req_valid = 1'b1;
    b.req_addr  = a;
    #1;
    chk("fetch_ready", DW'(b.req_ready), DW'(1'b1));
    tick();
    b.req_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    b.req_valid  = 1'b0; b.req_addr  = '0; b.stall  = 1'b0;
    b.ld_valid   = 1'b0; b.ld_addr   = '0; b.ld_data  = '0;
    b0.req_valid = 1'b0; b0.req_addr = '0; b0.stall = 1'b0;
    b0.ld_valid  = 1'b0; b0.ld_addr  = '0; b0.ld_data = '0;

    vecs[0] = '{11'h004, lanes(32'h1004, 32'h1005, 32'h1006, 32'h1007)};
    vecs[1] = '{11'h7FE, lanes(32'h27FE, 32'h27FF, 32'h2000, 32'h2001)};
    vecs[2] = '{11'h003, lanes(32'h1003, 32'h1004, 32'h1005, 32'h1006)};
    vecs[3] = '{11'h7FD, lanes(32'h27FD, 32'h27FE, 32'h27FF, 32'h2000)};
    vecs[4] = '{11'h000, lanes(32'h2000, 32'h2001, 32'h2002, 32'h1003)};
    vecs[5] = '{11'h002, lanes(32'h2002, 32'h1003, 32'h1004, 32'h1005)};
    vecs[6] = '{11'h7FF, lanes(32'h27FF, 32'h2000, 32'h2001, 32'h2002)};
    vecs[7] = '{11'h001, lanes(32'h2001, 32'h2002, 32'h1003, 32'h1004)};

    // reset state
    #12;
    chk("rst_rsp_valid", DW'(b.rsp_valid), DW'(1'b0));
    chk("rst_rsp_addr",  DW'(b.rsp_addr),  DW'(11'h000));
    chk("rst_rsp_data",  b.rsp_data,       DW'(1'b0));
    chk("rst_ld_count",  DW'(b.ld_count),  DW'(12'h000));
    chk("rst_req_ready", DW'(b.req_ready), DW'(1'b1));
    chk("rst_ld_ready",  DW'(b.ld_ready),  DW'(1'b1));
    chk("rst_ld_ready0", DW'(b0.ld_ready), DW'(1'b0));
    reset_n = 1'b1;
    tick();

    // aligned fetch
    for (int a = 0; a < 8; a++) load(AW'(a), 32'h1000 + 32'(a));
    chk("load8_count", DW'(b.ld_count), DW'(12'd8));
    fetch(11'h004);
    chk("aligned_valid", DW'(b.rsp_valid), DW'(1'b1));
    chk("aligned_addr",  DW'(b.rsp_addr),  DW'(11'h004));
    chk("aligned_data",  b.rsp_data, lanes(32'h1004, 32'h1005, 32'h1006, 32'h1007));
    tick();
    chk("idle_valid_drop", DW'(b.rsp_valid), DW'(1'b0));
    chk("idle_addr_hold",  DW'(b.rsp_addr),  DW'(11'h004));

    // words around the top of memory
    for (int i = 0; i < 6; i++) begin
      logic [AW-1:0] a;
      a = AW'(11'h7FD + 11'(i));
      load(a, 32'h2000 + 32'(a));
    end
    chk("load14_count", DW'(b.ld_count), DW'(12'd14));

    // back-to-back table of fetches
    b.req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b.req_addr = vecs[i].addr;
      #1;
      chk($sformatf("vec%0d_ready", i), DW'(b.req_ready), DW'(1'b1));
      tick();
      chk($sformatf("vec%0d_valid", i), DW'(b.rsp_valid), DW'(1'b1));
      chk($sformatf("vec%0d_addr", i),  DW'(b.rsp_addr),  DW'(vecs[i].addr));
      chk($sformatf("vec%0d_data", i),  b.rsp_data,       vecs[i].data);
    end
    b.req_valid = 1'b0;

    // stall hold, then release accepts in the same cycle
    fetch(11'h004);
    b.stall = 1'b1; b.req_valid = 1'b1; b.req_addr = 11'h000;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_ready", DW'(b.req_ready), DW'(1'b0));
      tick();
      chk("stall_valid", DW'(b.rsp_valid), DW'(1'b1));
      chk("stall_addr",  DW'(b.rsp_addr),  DW'(11'h004));
      chk("stall_data",  b.rsp_data, lanes(32'h1004, 32'h1005, 32'h1006, 32'h1007));
    end
    b.stall = 1'b0;
    #1;
    chk("release_ready", DW'(b.req_ready), DW'(1'b1));
    tick();
    chk("release_addr", DW'(b.rsp_addr), DW'(11'h000));
    chk("release_data", b.rsp_data, lanes(32'h2000, 32'h2001, 32'h2002, 32'h1003));
    b.req_valid = 1'b0;

    // loader priority over a pending fetch
    b.req_valid = 1'b1; b.req_addr = 11'h007;
    for (int c = 0; c < 3; c++) begin
      b.ld_valid = 1'b1; b.ld_addr = AW'(8 + c); b.ld_data = 32'h3008 + 32'(c);
      #1;
      chk("prio_ready", DW'(b.req_ready), DW'(1'b0));
      tick();
    end
    b.ld_valid = 1'b0;
    #1;
    chk("prio_after_ready", DW'(b.req_ready), DW'(1'b1));
    tick();
    chk("prio_addr",  DW'(b.rsp_addr), DW'(11'h007));
    chk("prio_data",  b.rsp_data, lanes(32'h1007, 32'h3008, 32'h3009, 32'h300A));
    chk("prio_count", DW'(b.ld_count), DW'(12'd17));

    // write into a held response leaves it alone, next fetch sees it
    b.stall = 1'b1; b.ld_valid = 1'b1; b.ld_addr = 11'h008; b.ld_data = 32'hBEEF_0008;
    #1;
    chk("heldwr_ready", DW'(b.req_ready), DW'(1'b0));
    tick();
    b.ld_valid = 1'b0;
    chk("heldwr_data",  b.rsp_data, lanes(32'h1007, 32'h3008, 32'h3009, 32'h300A));
    chk("heldwr_count", DW'(b.ld_count), DW'(12'd18));
    b.stall = 1'b0;
    tick();
    chk("rdafterwr_data", b.rsp_data, lanes(32'h1007, 32'hBEEF_0008, 32'h3009, 32'h300A));
    b.req_valid = 1'b0;

    // asynchronous reset while a stalled response is held
    fetch(11'h000);
    b.stall = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", DW'(b.rsp_valid), DW'(1'b0));
    chk("midrst_addr",  DW'(b.rsp_addr),  DW'(11'h000));
    chk("midrst_data",  b.rsp_data,       DW'(1'b0));
    chk("midrst_count", DW'(b.ld_count),  DW'(12'h000));
    chk("midrst_ready", DW'(b.req_ready), DW'(1'b1));
    tick();
    reset_n = 1'b1;
    b.stall = 1'b0;
    fetch(11'h004);
    chk("postrst_valid", DW'(b.rsp_valid), DW'(1'b1));
    chk("postrst_data",  b.rsp_data, lanes(32'h1004, 32'h1005, 32'h1006, 32'h1007));

    // ld_count wrap
    b.ld_valid = 1'b1; b.ld_addr = 11'h400; b.ld_data = 32'h0;
    for (int c = 0; c < 4095; c++) tick();
    chk("count_max", DW'(b.ld_count), DW'(12'hFFF));
    tick();
    b.ld_valid = 1'b0;
    chk("count_wrap", DW'(b.ld_count), DW'(12'h000));

    // loader disabled instance
    b0.req_valid = 1'b1; b0.req_addr = 11'h000;
    #1;
    chk("we0_ready_first", DW'(b0.req_ready), DW'(1'b1));
    tick();
    before_s = b0.rsp_data;
    b0.ld_valid = 1'b1; b0.ld_addr = 11'h000; b0.ld_data = 32'hDEAD_BEEF;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("we0_ld_ready",  DW'(b0.ld_ready),  DW'(1'b0));
      chk("we0_req_ready", DW'(b0.req_ready), DW'(1'b1));
      tick();
      chk("we0_ld_count",  DW'(b0.ld_count),  DW'(12'h000));
    end
    b0.ld_valid = 1'b0;
    tick();
    b0.req_valid = 1'b0;
    chk("we0_mem_unchanged", b0.rsp_data, before_s);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/imem_banked.md
# imem_banked

Parametrised, banked instruction memory that returns FETCH_W consecutive instructions starting from any word address, including fetches that cross a line boundary or wrap past the top of memory. It sits between the fetch stage and the instruction cache/loader path. It replaces the fixed 4-wide, line-aligned instruction memory with these additions:
- a registered response that holds under stall;
- a word-granular loader port, which has priority over fetch;
- a count of accepted loader writes.

## Interface
- INSN_LEN, 32, instruction width in bits
- FETCH_W, 4, instructions per fetch and number of banks; power of two, ≥1
- DEPTH, 512, rows per bank; power of two; total capacity is DEPTH*FETCH_W words
- WRITE_EN, 1, 1 enables the loader port; 0 ties ld_ready low and ignores ld_*
- AW (derived), $clog2(DEPTH)+$clog2(FETCH_W), word-address width
- clk  in  1  clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch request
- req_addr  in  AW  word address of the first instruction
- req_ready  out  1  fetch accepted this cycle when high together with req_valid
- stall  in  1  downstream cannot take the response; hold it
- rsp_valid  out  1  response valid
- rsp_addr  out  AW  req_addr of the held response
- rsp_data  out  FETCH_W*INSN_LEN  lane k (bits k*INSN_LEN +: INSN_LEN) = word (rsp_addr+k) mod 2^AW
- ld_valid  in  1  loader write request
- ld_addr  in  AW  word address to write
- ld_data  in  INSN_LEN  write data
- ld_ready  out  1  equals WRITE_EN; a write occurs on every cycle with ld_valid && ld_ready
- ld_count  out  AW+1  number of accepted loader writes, mod 2^(AW+1)

## Operation
- Storage: FETCH_W single-port banks of DEPTH×INSN_LEN. Word address a maps to bank a mod FETCH_W, row a / FETCH_W. Memory contents are not initialised and are not reset.
- Fetch, given off = req_addr mod FETCH_W and row = req_addr / FETCH_W:
  - bank i reads row (row + (i < off ? 1 : 0)) mod DEPTH;
  - the registered bank outputs are rotated by the registered off, so that lane k holds bank (off+k) mod FETCH_W.
- Arbitration: req_ready = !(WRITE_EN && ld_valid) && !(rsp_valid && stall). The loader always wins, and no fetch and write occur in the same cycle.
- Loader write: on an accepted write, bank ld_addr mod FETCH_W, row ld_addr / FETCH_W ← ld_data, and ld_count increments by 1.
- Response register, updated on each rising edge:
  - fetch accepted: rsp_valid←1, rsp_addr←req_addr, rsp_data←new read;
  - else if rsp_valid && stall: all response outputs hold;
  - else: rsp_valid←0; rsp_addr and rsp_data hold their last values.
- WRITE_EN=0: ld_ready=0, ld_count stays 0, and req_ready ignores ld_valid.

## Timing
- Reset (reset_n low, asynchronous): rsp_valid=0, rsp_addr=0, rsp_data=0, ld_count=0. req_ready then follows its combinational equation, so with ld_valid low it is 1. Memory is retained.
- Reset asserted mid-operation: a pending response is dropped. A write accepted on the edge before reset asserts is kept.
- Fetch latency: request accepted at edge T; data valid from T until the edge after it is consumed. Back-to-back fetches sustain 1 per cycle when stall=0 and ld_valid=0.
- Stall: while rsp_valid && stall, outputs are stable every cycle and req_ready=0. Deasserting stall lets a new request be accepted in that same cycle.
- Write→read ordering: a write accepted at edge T is visible to a fetch accepted at edge T+1 or later. A response already in rsp_data is not updated by later writes.
- Wrap-around: req_addr = 2^AW−1 returns words 2^AW−1, 0, 1, …; a row index of DEPTH wraps to 0.
- ld_count wraps from 2^(AW+1)−1 to 0.

## Test plan
Defaults: FETCH_W=4, DEPTH=512, AW=11.
- Aligned fetch: load words 0..7 with value 0x1000+addr, then fetch addr 4 → rsp_data lanes {0x1004, 0x1005, 0x1006, 0x1007}, rsp_valid one cycle after acceptance, ld_count=8.
- Unaligned/wrap: load 0x7FD..0x7FF and 0..2 with value 0x2000+addr, then fetch 0x7FE → lanes {0x27FE, 0x27FF, 0x2000, 0x2001}. Fetch 3 → lane 0 = word 3 and lane 3 = word 6, whatever those words hold.
- Stall hold: fetch 4, hold stall=1 for 5 cycles while req_valid=1 with addr 0 → req_ready=0 throughout, and rsp_addr=4 with data unchanged. Release stall → addr 0 accepted the same cycle.
- Loader priority: ld_valid=1 and req_valid=1 for 3 cycles → 3 writes, req_ready=0. The fetch issues the cycle after ld_valid drops and returns the new data. A write to a word inside the held response does not alter rsp_data.
- Reset mid-op: assert reset_n=0 while rsp_valid=1 and stall=1 → rsp_valid, rsp_data and ld_count read 0 immediately. After release, fetch 4 returns {0x1004..0x1007} (memory retained).
- WRITE_EN=0 instance: drive ld_valid=1 for 4 cycles → ld_ready=0, ld_count=0, req_ready unaffected, and memory unchanged.
